// File: rtl/serial_div_pkg.sv
// Shared constants for the Wishbone serial divider: register map, CTRL/STATUS
// bit positions and the divider FSM state encoding.
package serial_div_pkg;

  localparam logic [2:0] REG_DIVIDEND  = 3'd0;
  localparam logic [2:0] REG_DIVISOR   = 3'd1;
  localparam logic [2:0] REG_CTRL      = 3'd2;
  localparam logic [2:0] REG_STATUS    = 3'd3;
  localparam logic [2:0] REG_QUOTIENT  = 3'd4;
  localparam logic [2:0] REG_REMAINDER = 3'd5;

  localparam int CTRL_START  = 0;
  localparam int CTRL_SIGNED = 1;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_DIV0 = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_div_core.sv
// Restoring shift-subtract divider, one quotient bit per cycle: IDLE -> CALC -> FIX.
// Signed operation is built in only when SERIAL_DIV_SIGNED_EN is defined.
module serial_div_core
  import serial_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_signed,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_start,
  output logic            o_fini,
  output logic            o_done,
  output logic            o_div0,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder,
  output state_e          o_state
);

  localparam int CW = $clog2(XLEN);

  state_e          r_state, w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem, r_quo, r_dvs, r_q_out, r_r_out;
  logic            r_zero, r_start, r_fini, r_done, r_div0;
  logic [XLEN:0]   w_shift, w_diff;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_q_fix, w_r_fix;
  logic            w_div_zero;

  assign w_div_zero = (i_divisor == '0);
  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs};

`ifdef SERIAL_DIV_SIGNED_EN
  logic r_neg_q, r_neg_r;

  assign w_a_mag = (i_signed && i_dividend[XLEN-1]) ? -i_dividend : i_dividend;
  assign w_b_mag = (i_signed && i_divisor[XLEN-1])  ? -i_divisor  : i_divisor;
  assign w_q_fix = r_neg_q ? -r_quo : r_quo;
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;

  // Remainder follows the dividend sign so that quotient truncates toward zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_neg_q <= i_signed & (i_dividend[XLEN-1] ^ i_divisor[XLEN-1]);
      r_neg_r <= i_signed & i_dividend[XLEN-1];
    end
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = i_signed;
  assign w_a_mag = i_dividend;
  assign w_b_mag = i_divisor;
  assign w_q_fix = r_quo;
  assign w_r_fix = r_rem;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_next = w_div_zero ? ST_FIX : ST_CALC;
      ST_CALC: if (r_cnt == '0) w_state_next = ST_FIX;
      ST_FIX:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // On divide-by-zero r_quo carries the raw dividend straight to FIX as the remainder.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_zero  <= 1'b0;
      r_start <= 1'b0;
      r_fini  <= 1'b0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_fini  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_start <= 1'b1;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
            r_rem   <= '0;
            r_cnt   <= CW'(XLEN - 1);
            r_zero  <= w_div_zero;
            r_quo   <= w_div_zero ? i_dividend : w_a_mag;
            r_dvs   <= w_b_mag;
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt - CW'(1);
          if (!w_diff[XLEN]) begin
            r_rem <= w_diff[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b0};
          end
        end
        ST_FIX: begin
          r_fini  <= 1'b1;
          r_done  <= 1'b1;
          r_div0  <= r_zero;
          r_q_out <= r_zero ? '1 : w_q_fix;
          r_r_out <= r_zero ? r_quo : w_r_fix;
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_start     = r_start;
  assign o_fini      = r_fini;
  assign o_done      = r_done;
  assign o_div0      = r_div0;
  assign o_quotient  = r_q_out;
  assign o_remainder = r_r_out;
  assign o_state     = r_state;

endmodule

// File: rtl/wb_serial_divider.sv
// Wishbone slave front end of the serial divider: register decode, byte-lane
// operand writes and single-cycle ack. Signed mode via SERIAL_DIV_SIGNED_EN.
module wb_serial_divider
  import serial_div_pkg::*;
#(
  parameter int WBW  = 32,
  parameter int XLEN = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [WBW/8-1:0] wbs_sel_i,
  input  logic [WBW-1:0]   wbs_adr_i,
  input  logic [WBW-1:0]   wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [WBW-1:0]   wbs_dat_o,
  output logic             busy_o,
  output logic             start_o,
  output logic             fini_o
);

  logic            r_ack;
  logic [WBW-1:0]  r_dat, w_rd;
  logic [XLEN-1:0] r_dividend, r_divisor;
  logic [2:0]      w_off;
  logic            w_accept, w_wr, w_start;
  logic            w_busy, w_done, w_div0;
  logic [XLEN-1:0] w_quo, w_rem;
  state_e          w_state;
  logic            w_unused;

  assign w_off    = wbs_adr_i[4:2];
  assign w_accept = wbs_stb_i & wbs_cyc_i & ~r_ack;
  assign w_wr     = w_accept & wbs_we_i;
  assign w_start  = w_wr & (w_off == REG_CTRL) & wbs_dat_i[CTRL_START] & ~w_busy;
  assign w_unused = ^{wbs_adr_i, wbs_dat_i, wbs_sel_i, w_state};

  always_comb begin
    w_rd = '0;
    case (w_off)
      REG_DIVIDEND:  w_rd = WBW'(r_dividend);
      REG_DIVISOR:   w_rd = WBW'(r_divisor);
      REG_STATUS: begin
        w_rd[STAT_BUSY] = w_busy;
        w_rd[STAT_DONE] = w_done;
        w_rd[STAT_DIV0] = w_div0;
      end
      REG_QUOTIENT:  w_rd = WBW'(w_quo);
      REG_REMAINDER: w_rd = WBW'(w_rem);
      default:       w_rd = '0;
    endcase
  end

  // Operand writes land bit by bit under their byte-lane select; frozen while busy.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
    end else begin
      r_ack <= w_accept;
      r_dat <= (w_accept && !wbs_we_i) ? w_rd : '0;
      if (w_wr && !w_busy) begin
        for (int i = 0; i < XLEN; i++) begin
          if (wbs_sel_i[i/8]) begin
            if (w_off == REG_DIVIDEND) r_dividend[i] <= wbs_dat_i[i];
            if (w_off == REG_DIVISOR)  r_divisor[i]  <= wbs_dat_i[i];
          end
        end
      end
    end
  end

  serial_div_core #(.XLEN(XLEN)) u_core (
    .i_clk       (clk_i),
    .i_rst_n     (reset_ni),
    .i_start     (w_start),
    .i_signed    (wbs_dat_i[CTRL_SIGNED]),
    .i_dividend  (r_dividend),
    .i_divisor   (r_divisor),
    .o_busy      (w_busy),
    .o_start     (start_o),
    .o_fini      (fini_o),
    .o_done      (w_done),
    .o_div0      (w_div0),
    .o_quotient  (w_quo),
    .o_remainder (w_rem),
    .o_state     (w_state)
  );

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign busy_o    = w_busy;

endmodule

// File: tb/tb_wb_serial_divider.sv
// Bench for wb_serial_divider: an XLEN=32 and an XLEN=8 instance share one bus;
// read data is checked from an expected-value queue, fini timing per DUT.
module tb_wb_serial_divider;

  logic        clk, reset_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w;
  logic        ack32, busy32, start32, fini32;
  logic        ack8, busy8, start8, fini8;
  logic [31:0] dat32, dat8;

  int n_checks = 0;
  int n_fail   = 0;
  int ncnt     = 0;
  int fini_cnt = 0, fini_at = 0, fini8_cnt = 0, fini8_at = 0;
  int start_n  = 0, last_acc_n = 0;
  bit rd_pend  = 0;

  logic [31:0] exp_q[$];
  bit          dut_q[$];
  string       tag_q[$];

`ifdef SERIAL_DIV_SIGNED_EN
  localparam logic [31:0] NEG_Q = 32'hFFFF_FFFD, NEG_R = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_Q = 32'h8000_0000, OVF_R = 32'h0;
`else
  localparam logic [31:0] NEG_Q = 32'h7FFF_FFFC, NEG_R = 32'h1;
  localparam logic [31:0] OVF_Q = 32'h0, OVF_R = 32'h8000_0000;
`endif

  wb_serial_divider #(.WBW(32), .XLEN(32)) dut (
    .clk_i(clk), .reset_ni(reset_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack32),
    .wbs_dat_o(dat32), .busy_o(busy32), .start_o(start32), .fini_o(fini32)
  );

  wb_serial_divider #(.WBW(32), .XLEN(8)) dut8 (
    .clk_i(clk), .reset_ni(reset_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack8),
    .wbs_dat_o(dat8), .busy_o(busy8), .start_o(start8), .fini_o(fini8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    ncnt++;
    if (fini32) begin fini_cnt++; fini_at = ncnt; end
    if (fini8)  begin fini8_cnt++; fini8_at = ncnt; end
    if (rd_pend && ack32 && exp_q.size() > 0) begin
      automatic logic [31:0] e = exp_q.pop_front();
      automatic bit          d = dut_q.pop_front();
      automatic string       t = tag_q.pop_front();
      check(t, d ? dat8 : dat32, e);
    end
  end

  // drivers
  task automatic wb_write(input logic [2:0] off, input logic [31:0] data, input logic [3:0] s);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = {27'd0, off, 2'b00}; dat_w = data; sel = s;
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    last_acc_n = ncnt;
    @(negedge clk); #1;
    check("wr_ack", {31'd0, ack32}, 32'd1);
  endtask

  task automatic wb_read(input logic [2:0] off, input logic [31:0] exp, input bit is8, input string tag);
    exp_q.push_back(exp); dut_q.push_back(is8); tag_q.push_back(tag);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = {27'd0, off, 2'b00}; sel = 4'hF;
    rd_pend = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk); #1;
    rd_pend = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] ctrl);
    wb_write(3'd2, ctrl, 4'hF);
    start_n = last_acc_n;
    check("start_pulse_c1", {31'd0, start32}, 32'd1);
    check("busy_c1", {31'd0, busy32}, 32'd1);
  endtask

  task automatic wait_cycle(input int k);
    while (ncnt < start_n + k - 1) begin @(negedge clk); #1; end
  endtask

  task automatic wait_fini(input bit is8, input int budget, input int exp_lat, input string tag);
    int c0, waited;
    bit seen;
    c0 = is8 ? fini8_cnt : fini_cnt;
    seen = 0; waited = 0;
    while (!seen && waited < budget) begin
      @(negedge clk); #1;
      waited++;
      seen = ((is8 ? fini8_cnt : fini_cnt) != c0);
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    else check({tag, "_lat"}, 32'((is8 ? fini8_at : fini_at) - start_n), 32'(exp_lat));
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ctrl,
                         input logic [31:0] eq, input logic [31:0] er, input logic [31:0] es,
                         input int lat, input string tag);
    wb_write(3'd0, a, 4'hF);
    wb_write(3'd1, b, 4'hF);
    do_start(ctrl);
    if (lat > 5) wb_read(3'd3, 32'd1, 0, {tag, "_stat_busy"});
    wait_fini(0, 100, lat, tag);
    wb_read(3'd4, eq, 0, {tag, "_quo"});
    wb_read(3'd5, er, 0, {tag, "_rem"});
    wb_read(3'd3, es, 0, {tag, "_stat"});
    wb_read(3'd3, es, 0, {tag, "_stat_sticky"});
  endtask

  initial begin
    int f0;
    stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; dat_w = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, ack32}, 32'd0);
    check("rst_busy", {31'd0, busy32}, 32'd0);
    check("rst_start", {31'd0, start32}, 32'd0);
    check("rst_fini", {31'd0, fini32}, 32'd0);
    check("rst_dat", dat32, 32'd0);
    #1 reset_n = 1'b1;
    for (int r = 0; r < 6; r++) wb_read(3'(r), 32'd0, 0, "rst_reg");

    // held strobe: ack must alternate, never two in a row
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h1C; dat_w = 32'h0; sel = 4'hF;
    @(negedge clk); check("b2b_ack1", {31'd0, ack32}, 32'd1);
    @(negedge clk); check("b2b_gap", {31'd0, ack32}, 32'd0);
    @(negedge clk); check("b2b_ack2", {31'd0, ack32}, 32'd1);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;

    // byte lanes and unmapped offsets
    wb_write(3'd0, 32'hFFFF_FFFF, 4'hF);
    wb_write(3'd0, 32'h1234_5678, 4'b0101);
    wb_read(3'd0, 32'hFF34_FF78, 0, "sel_dividend");
    wb_write(3'd1, 32'hAABB_CCDD, 4'b1000);
    wb_read(3'd1, 32'hAA00_0000, 0, "sel_divisor");
    wb_write(3'd6, 32'hDEAD_BEEF, 4'hF);
    wb_read(3'd6, 32'd0, 0, "unmapped6");
    wb_read(3'd7, 32'd0, 0, "unmapped7");
    wb_read(3'd2, 32'd0, 0, "ctrl_read");

    run_div(32'd100, 32'd7, 32'd1, 32'd14, 32'd2, 32'd2, 34, "u100_7");
    run_div(-32'sd7, 32'd2, 32'd3, NEG_Q, NEG_R, 32'd2, 34, "s_m7_2");
    run_div(32'h1234, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'h1234, 32'd6, 2, "div0");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 32'd3, OVF_Q, OVF_R, 32'd2, 34, "ovf");
    for (int k = 0; k < 3; k++) begin
      automatic logic [31:0] a = $urandom_range(32'h7FFF_FFFF, 0);
      automatic logic [31:0] b = $urandom_range(32'hFFFF, 1);
      run_div(a, b, 32'd1, a / b, a % b, 32'd2, 34, "rand_u");
    end

    // busy protection
    f0 = fini_cnt;
    wb_write(3'd0, 32'd1000, 4'hF);
    wb_write(3'd1, 32'd10, 4'hF);
    do_start(32'd1);
    wait_cycle(10);
    wb_write(3'd2, 32'd1, 4'hF);
    wb_write(3'd1, 32'd3, 4'hF);
    wait_fini(0, 100, 34, "busy_prot");
    repeat (40) @(negedge clk);
    #1 check("busy_one_fini", 32'(fini_cnt - f0), 32'd1);
    wb_read(3'd4, 32'd100, 0, "busy_quo");
    wb_read(3'd5, 32'd0, 0, "busy_rem");
    wb_read(3'd1, 32'd10, 0, "busy_divisor");

    // abort by reset mid-division
    wb_write(3'd0, 32'd500, 4'hF);
    wb_write(3'd1, 32'd7, 4'hF);
    do_start(32'd1);
    f0 = fini_cnt;
    wait_cycle(15);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (40) @(negedge clk);
    #1 check("abort_no_fini", 32'(fini_cnt - f0), 32'd0);
    check("abort_busy", {31'd0, busy32}, 32'd0);
    for (int r = 0; r < 6; r++) wb_read(3'(r), 32'd0, 0, "abort_reg");

    // 8-bit instance alongside the 32-bit one
    wb_write(3'd0, 32'd200, 4'hF);
    wb_write(3'd1, 32'd3, 4'hF);
    do_start(32'd1);
    wait_fini(1, 100, 10, "x8");
    wait_fini(0, 100, 34, "x32_200_3");
    wb_read(3'd4, 32'd66, 1, "x8_quo");
    wb_read(3'd5, 32'd2, 1, "x8_rem");
    wb_read(3'd4, 32'd66, 0, "x32_quo");
    wb_read(3'd5, 32'd2, 0, "x32_rem");

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
